// File: rtl/i_type_alu.sv
// Single-cycle RV32I register-immediate ALU with a registered result.
// Only funct3 and instr[30] steer the operation; every other instruction field is ignored.
module i_type_alu (
    input  logic               clk,
    input  logic               rst_n,
    input  logic        [31:0] instr,
    input  logic signed [31:0] in1,
    input  logic signed [31:0] imm,
    input  logic               in_valid,
    output logic signed [31:0] out,
    output logic               out_valid
);

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SLT,
        OP_SLTU,
        OP_XOR,
        OP_OR,
        OP_AND,
        OP_SLL,
        OP_SRL,
        OP_SRA
    } op_t;

    logic        [2:0]  funct3;
    logic               shift_arith;
    logic        [4:0]  shamt;
    op_t                op;
    logic signed [31:0] result;
    logic               unused_instr_bits;

    assign funct3      = instr[14:12];
    assign shift_arith = instr[30];
    assign shamt       = imm[4:0];

    // Opcode, rd, rs1 and the remaining funct7 bits are deliberately not decoded.
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:0]};

    always_comb begin
        op = OP_ADD;
        case (funct3)
            3'b000:  op = OP_ADD;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b110:  op = OP_OR;
            3'b111:  op = OP_AND;
            3'b001:  op = OP_SLL;
            3'b101:  op = shift_arith ? OP_SRA : OP_SRL;
            default: op = OP_ADD;
        endcase
    end

    // Compare results are zero-extended to a full word (0 or 1).
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = in1 + imm;
            OP_SLT:  result = {31'd0, (in1 < imm)};
            OP_SLTU: result = {31'd0, ($unsigned(in1) < $unsigned(imm))};
            OP_XOR:  result = in1 ^ imm;
            OP_OR:   result = in1 | imm;
            OP_AND:  result = in1 & imm;
            OP_SLL:  result = in1 << shamt;
            OP_SRL:  result = in1 >> shamt;
            OP_SRA:  result = in1 >>> shamt;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= result;
            end
        end
    end

endmodule

// File: tb/tb_i_type_alu.sv
// Scoreboard bench for i_type_alu: expected results are queued at drive time
// and popped by a negedge monitor whenever out_valid is seen.
module tb_i_type_alu;

    logic               clk;
    logic               rst_n;
    logic        [31:0] instr;
    logic signed [31:0] in1;
    logic signed [31:0] imm;
    logic               in_valid;
    logic signed [31:0] out;
    logic               out_valid;

    logic [31:0] expq[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          valid_run  = 0;
    int          last_run   = 0;

    i_type_alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .in1       (in1),
        .imm       (imm),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Reference written straight from the instruction semantics.
    function automatic logic [31:0] modelAlu(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        logic [4:0]  sh;
        logic [31:0] fill;
        logic [31:0] r;
        sh   = b[4:0];
        fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
        r    = 32'd0;
        case (ins[14:12])
            3'd0: r = a + b;
            3'd1: r = a << sh;
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = ins[30] ? ((a >> sh) | fill) : (a >> sh);
            3'd6: r = a | b;
            3'd7: r = a & b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input logic [31:0] expected);
        instr    = ins;
        in1      = a;
        imm      = b;
        in_valid = 1'b1;
        expq.push_back(expected);
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            valid_run++;
            if (expq.size() == 0) begin
                checkOutput("unexpected_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                checkOutput("result", out, expq.pop_front());
            end
        end else begin
            if (valid_run != 0) last_run = valid_run;
            valid_run = 0;
        end
    end

    initial begin
        logic [31:0] rins;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n    = 1'b0;
        instr    = '0;
        in1      = '0;
        imm      = '0;
        in_valid = 1'b0;
        #1;
        checkOutput("reset_out", out, 32'd0);
        checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed funct3 set, issued back to back.
        applyStimulus(32'h0000_0000, 617, 511, 1128);
        applyStimulus(32'h0000_1000, 989, 295, 126592);
        applyStimulus(32'h0000_3000, 980, 533, 0);
        applyStimulus(32'h0000_A000, 234, 592, 1);
        applyStimulus(32'h0000_6000, 679, 91, 767);
        applyStimulus(32'h0000_F000, 503, 746, 226);
        applyStimulus(32'h0001_5000, 843, 750, 0);
        applyStimulus(32'h0001_C000, 949, 372, 705);
        idleCycles(2);

        // Shifts, compares and boundaries.
        applyStimulus(32'h4000_5000, -16, 2, -4);
        applyStimulus(32'h0000_5000, -16, 2, 32'h3FFF_FFFC);
        applyStimulus(32'h0000_2000, -1, 0, 1);
        applyStimulus(32'h0000_3000, -1, 0, 0);
        applyStimulus(32'h0000_0000, 32'h7FFF_FFFF, 1, 32'h8000_0000);
        applyStimulus(32'h0000_1000, 32'h1234_5678, 32, 32'h1234_5678);
        applyStimulus(32'h4000_5000, 32'h8765_4321, 32'hFFFF_FFE0, 32'h8765_4321);
        applyStimulus(32'h0000_1000, 32'h0000_0003, 32'hFFFF_FFE1, 32'h0000_0006);
        applyStimulus(32'hBFFF_AFFF, 32'h8000_0000, 31, 32'h0000_0001);
        idleCycles(2);

        // Hold: result stays put with out_valid low.
        applyStimulus(32'h0001_C000, 949, 372, 705);
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold_out", out, 705);
            checkOutput("hold_valid", {31'd0, out_valid}, 32'd0);
        end

        // Asynchronous reset between edges, with a transaction pending during reset.
        applyStimulus(32'h0000_0000, 617, 511, 1128);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("pre_reset_out", out, 1128);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_out", out, 32'd0);
        checkOutput("async_reset_valid", {31'd0, out_valid}, 32'd0);
        instr    = 32'h0000_0000;
        in1      = 100;
        imm      = 200;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_reset_out", out, 32'd0);
        checkOutput("in_reset_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_out", out, 32'd0);
        checkOutput("post_reset_valid", {31'd0, out_valid}, 32'd0);

        // Back-to-back burst of four.
        applyStimulus(32'h0000_0000, 10, 20, 30);
        applyStimulus(32'h0000_4000, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F);
        applyStimulus(32'h0000_1000, 1, 31, 32'h8000_0000);
        applyStimulus(32'h4000_5000, 32'h8000_0000, 31, 32'hFFFF_FFFF);
        idleCycles(2);
        checkOutput("b2b_run", last_run, 32'd4);

        // Random operations with junk in the ignored instruction fields.
        for (int i = 0; i < 24; i++) begin
            rins = $urandom;
            ra   = $urandom;
            rb   = (i % 3 == 0) ? $urandom_range(0, 40) : $urandom;
            applyStimulus(rins, ra, rb, modelAlu(rins, ra, rb));
            if (i % 5 == 4) idleCycles(1);
        end
        in_valid = 1'b0;

        for (int i = 0; i < 5 && expq.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        checkOutput("drain", expq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/i_type_alu.md
I_TYPE_ALU -- requirements
Module: I_type

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32 bits.
REQ-002 clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 instr  input  32  I-type instruction word; funct3 = instr[14:12], shift-type bit = instr[30].
REQ-005 in1  input  32  rs1 operand, signed two's complement.
REQ-006 imm  input  32  immediate, already sign-extended by the caller, signed.
REQ-007 in_valid  input  1  qualifies instr/in1/imm for capture this cycle.
REQ-008 out  output  32  registered result, signed.
REQ-009 out_valid  output  1  high for one cycle when out holds a new result.

Function
REQ-010 On each rising clk with in_valid=1, the block SHALL compute a result from funct3 and register it into out.
- Latency is exactly 1 cycle.
- out_valid = registered copy of in_valid.
REQ-011 With in_valid=0, out SHALL hold its previous value and out_valid SHALL be 0.
REQ-012 The funct3 decode SHALL be as follows.
- 000 ADDI: in1+imm, modulo 2^32, with no overflow flag.
- 010 SLTI: 1 if signed in1 < signed imm, else 0.
- 011 SLTIU: 1 if unsigned in1 < unsigned imm, else 0.
- 100 XORI: in1^imm.
- 110 ORI: in1|imm.
- 111 ANDI: in1&imm.
- 001 SLLI: in1 << imm[4:0].
- 101 with instr[30]=0 SRLI: logical in1 >> imm[4:0].
- 101 with instr[30]=1 SRAI: arithmetic in1 >>> imm[4:0].
REQ-013 The shift amount SHALL use only imm[4:0]; imm[31:5] SHALL be ignored for shifts.
REQ-014 All instr bits other than [14:12] and [30] SHALL be ignored; opcode, rd and rs1 fields are not checked.
REQ-015 The SLT/SLTU results SHALL be zero-extended to 32 bits (value 0 or 1).
REQ-016 Back-to-back in_valid SHALL be accepted every cycle with no stall and no backpressure.
REQ-017 Boundary behaviour SHALL be as follows.
- Shift by 0: out = in1.
- ADDI 0x7FFFFFFF+1: out = 0x80000000.
- SLTI -1 vs 0: out = 1.
- SLTIU 0xFFFFFFFF vs 0: out = 0.

Reset
REQ-018 While rst_n=0, out SHALL be 0 and out_valid SHALL be 0, immediately and independent of clk.
REQ-019 Assertion of rst_n mid-operation SHALL discard any in-flight result.
REQ-020 The first capture after reset SHALL occur on the first rising clk with rst_n=1 and in_valid=1.

Verification
REQ-021 Bench SHALL cover the funct3 directed set below, each with in_valid=1 and a check one cycle later.
- instr=0x00000000, in1=617, imm=511 -> out=1128 (ADDI).
- instr=0x00001000, in1=989, imm=295 -> out=126592 (SLLI by 7).
- instr=0x00003000, in1=980, imm=533 -> out=0 (SLTIU).
- instr=0x0000A000, in1=234, imm=592 -> out=1 (SLTI).
- instr=0x00006000, in1=679, imm=91 -> out=767 (ORI).
- instr=0x0000F000, in1=503, imm=746 -> out=226 (ANDI).
- instr=0x00015000, in1=843, imm=750 -> out=0 (SRLI by 14).
- instr=0x0001C000, in1=949, imm=372 -> out=705 (XORI).
REQ-022 Bench SHALL cover SRAI: instr=0x40005000, in1=-16, imm=2 -> out=-4; the same with instr[30]=0 -> out=0x3FFFFFFC.
REQ-023 Bench SHALL cover signed compare: SLTI in1=-1, imm=0 -> 1; SLTIU with the same operands -> 0.
REQ-024 Bench SHALL cover hold: in_valid=0 for 3 cycles after a result -> out unchanged, out_valid=0.
REQ-025 Bench SHALL cover async reset: assert rst_n=0 between clock edges while out=1128 -> out=0 and out_valid=0 immediately, before the next edge.
REQ-026 Bench SHALL cover back-to-back operation: 4 consecutive in_valid cycles -> 4 consecutive out_valid cycles, with results in order.
